// File: rtl/clk_freq_monitor.sv
//------------------------------------------------------------------------------
// clk_freq_monitor
//
// Measures the frequency of an asynchronous signal by counting its rising
// edges over a fixed gate window of WINDOW system-clock cycles. It is used to
// confirm that each PLL/board clock output is alive and in range. Fast clocks
// are expected to be pre-divided in their own domain before reaching meas_in.
//
// Timing: count_valid is high for the single LATCH cycle that closes a window.
// freq_count, in_range, stuck, overflow and locked load at the end of that
// cycle and are visible from the following cycle onward. Consecutive
// count_valid pulses are WINDOW+1 cycles apart while enable stays high.
//
// Optional feature (macro CLKMON_HIST_EN): adds min/max history registers of
// the window counts, cleared by reset or hist_clear.
//
// Parameters:
//   WINDOW       gate length in FPGA_CLK1_50 cycles (>= 2)
//   CW           width of the edge counter and count outputs (<= 64)
//   MIN_COUNT    lowest in-range count (inclusive)
//   MAX_COUNT    highest in-range count (inclusive)
//   LOCK_WINDOWS consecutive in-range windows required for locked
//
// Ports:
//   FPGA_CLK1_50  in   system clock, all logic on its rising edge
//   reset         in   synchronous active-high reset
//   meas_in       in   asynchronous monitored signal (< FPGA_CLK1_50/3)
//   enable        in   high: windows run; low: gate held idle
//   hist_clear    in   (CLKMON_HIST_EN) restore history clear values
//   freq_count    out  edge count of the last completed window
//   count_valid   out  one-cycle pulse marking the window close
//   in_range      out  last count within [MIN_COUNT, MAX_COUNT]
//   stuck         out  last window had zero edges
//   locked        out  LOCK_WINDOWS consecutive in-range windows seen
//   overflow      out  last window's edge counter saturated
//   hist_min      out  (CLKMON_HIST_EN) smallest count since clear
//   hist_max      out  (CLKMON_HIST_EN) largest count since clear
//------------------------------------------------------------------------------
module clk_freq_monitor #(
    parameter int WINDOW       = 50000,
    parameter int CW           = 16,
    parameter int MIN_COUNT    = 12200,
    parameter int MAX_COUNT    = 12400,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic          FPGA_CLK1_50,
    input  logic          reset,
    input  logic          meas_in,
    input  logic          enable,
`ifdef CLKMON_HIST_EN
    input  logic          hist_clear,
    output logic [CW-1:0] hist_min,
    output logic [CW-1:0] hist_max,
`endif
    output logic [CW-1:0] freq_count,
    output logic          count_valid,
    output logic          in_range,
    output logic          stuck,
    output logic          locked,
    output logic          overflow
);

    localparam int GW = $clog2(WINDOW);
    localparam int LW = (LOCK_WINDOWS > 0) ? $clog2(LOCK_WINDOWS + 1) : 1;

    localparam logic [GW-1:0] GATE_LAST = GW'(WINDOW - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WINDOWS);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    // An inverted range is illegal; it simply never reports in range.
    localparam bit            RANGE_OK  = (MIN_COUNT <= MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        LATCH
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           abort;

    logic           meas_p0;
    logic           meas_p1;
    logic           meas_p2;
    logic           edge_det;

    logic [GW-1:0]  gate_cnt;
    logic [CW-1:0]  edge_cnt;
    logic           sat_seen;
    logic [LW-1:0]  consec_cnt;
    logic [LW-1:0]  consec_nxt;
    logic           win_ok;

    //--------------------------------------------------------------------------
    // Saturation / range helpers
    //--------------------------------------------------------------------------
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    function automatic logic [LW-1:0] lock_inc(input logic [LW-1:0] c);
        return (c >= LOCK_LAST) ? LOCK_LAST : c + LW'(1);
    endfunction

    // The count is zero-extended so thresholds wider than CW compare correctly.
    function automatic logic count_in_range(input logic [CW-1:0] c);
        logic [63:0] v;
        v = 64'(c);
        return RANGE_OK && (v >= 64'(MIN_COUNT)) && (v <= 64'(MAX_COUNT));
    endfunction

    //--------------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizer; p2: edge-detect history
    //--------------------------------------------------------------------------
    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            meas_p0 <= 1'b0;
            meas_p1 <= 1'b0;
            meas_p2 <= 1'b0;
        end else begin
            meas_p0 <= meas_in;
            meas_p1 <= meas_p0;
            meas_p2 <= meas_p1;
        end
    end

    assign edge_det = meas_p1 & ~meas_p2;

    //--------------------------------------------------------------------------
    // Gate FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_valid = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                // Dropping enable wins even on the last gate cycle.
                if (!enable) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (gate_cnt == GATE_LAST) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                count_valid = 1'b1;
                state_nxt   = enable ? COUNT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Gate and edge counters
    //--------------------------------------------------------------------------
    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_seen <= 1'b0;
        end else begin
            case (state)
                COUNT: begin
                    if (abort) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat_seen <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        if (edge_det) begin
                            edge_cnt <= sat_inc(edge_cnt);
                            if (edge_cnt == CNT_MAX) begin
                                sat_seen <= 1'b1;
                            end
                        end
                    end
                end
                LATCH: begin
                    // An edge seen while latching opens the next window.
                    gate_cnt <= '0;
                    edge_cnt <= (edge_det && enable) ? CW'(1) : '0;
                    sat_seen <= 1'b0;
                end
                default: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat_seen <= 1'b0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Window results and lock tracking
    //--------------------------------------------------------------------------
    assign win_ok     = count_in_range(edge_cnt);
    assign consec_nxt = lock_inc(consec_cnt);

    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            freq_count <= '0;
            in_range   <= 1'b0;
            stuck      <= 1'b0;
            overflow   <= 1'b0;
            locked     <= 1'b0;
            consec_cnt <= '0;
        end else if (state == LATCH) begin
            freq_count <= edge_cnt;
            in_range   <= win_ok;
            stuck      <= (edge_cnt == '0);
            overflow   <= sat_seen;
            if (win_ok) begin
                consec_cnt <= consec_nxt;
                locked     <= (consec_nxt == LOCK_LAST);
            end else begin
                consec_cnt <= '0;
                locked     <= 1'b0;
            end
        end else if (abort) begin
            // An aborted window keeps the last results but loses lock.
            consec_cnt <= '0;
            locked     <= 1'b0;
        end
    end

`ifdef CLKMON_HIST_EN
    //--------------------------------------------------------------------------
    // Count history; a clear coinciding with LATCH drops that window's count
    //--------------------------------------------------------------------------
    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset || hist_clear) begin
            hist_min <= CNT_MAX;
            hist_max <= '0;
        end else if (state == LATCH) begin
            if (edge_cnt < hist_min) begin
                hist_min <= edge_cnt;
            end
            if (edge_cnt > hist_max) begin
                hist_max <= edge_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
//------------------------------------------------------------------------------
// tb_clk_freq_monitor
//
// Two instances share all inputs: u_dut (CW=16) for range/lock behaviour and
// u_ovf (CW=4) for counter saturation. A reference model works on the raw,
// unbounded number of edges per window and derives every expectation from it.
// Window results are pushed to a scoreboard queue when the model closes a
// window; a monitor pops and compares whenever count_valid is seen.
//------------------------------------------------------------------------------
module tb_clk_freq_monitor;

    localparam int W     = 100;
    localparam int MINC  = 24;
    localparam int MAXC  = 26;
    localparam int LOCKN = 4;

    logic        clk;
    logic        reset;
    logic        meas_in;
    logic        enable;
    logic [15:0] freq_count;
    logic        count_valid;
    logic        in_range;
    logic        stuck;
    logic        locked;
    logic        overflow;
    logic [3:0]  freq_count4;
    logic        count_valid4;
    logic        in_range4;
    logic        stuck4;
    logic        locked4;
    logic        overflow4;
`ifdef CLKMON_HIST_EN
    logic        hist_clear;
    logic [15:0] hist_min;
    logic [15:0] hist_max;
    logic [3:0]  hist_min4;
    logic [3:0]  hist_max4;
`endif

    int checks = 0;
    int errors = 0;

    clk_freq_monitor #(
        .WINDOW(W), .CW(16), .MIN_COUNT(MINC), .MAX_COUNT(MAXC), .LOCK_WINDOWS(LOCKN)
    ) u_dut (
        .FPGA_CLK1_50(clk),
        .reset       (reset),
        .meas_in     (meas_in),
        .enable      (enable),
`ifdef CLKMON_HIST_EN
        .hist_clear  (hist_clear),
        .hist_min    (hist_min),
        .hist_max    (hist_max),
`endif
        .freq_count  (freq_count),
        .count_valid (count_valid),
        .in_range    (in_range),
        .stuck       (stuck),
        .locked      (locked),
        .overflow    (overflow)
    );

    clk_freq_monitor #(
        .WINDOW(W), .CW(4), .MIN_COUNT(MINC), .MAX_COUNT(MAXC), .LOCK_WINDOWS(LOCKN)
    ) u_ovf (
        .FPGA_CLK1_50(clk),
        .reset       (reset),
        .meas_in     (meas_in),
        .enable      (enable),
`ifdef CLKMON_HIST_EN
        .hist_clear  (hist_clear),
        .hist_min    (hist_min4),
        .hist_max    (hist_max4),
`endif
        .freq_count  (freq_count4),
        .count_valid (count_valid4),
        .in_range    (in_range4),
        .stuck       (stuck4),
        .locked      (locked4),
        .overflow    (overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    //--------------------------------------------------------------------------
    // meas_in generator: period-4 square wave, or random half periods of 2..3
    //--------------------------------------------------------------------------
    bit wave_on   = 1'b0;
    bit wave_rand = 1'b0;
    int ph        = 0;

    initial meas_in = 1'b0;

    always @(negedge clk) begin
        if (!wave_on) begin
            meas_in = 1'b0;
            ph      = 0;
        end else if (ph <= 1) begin
            meas_in = ~meas_in;
            ph      = wave_rand ? int'($urandom_range(2, 3)) : 2;
        end else begin
            ph--;
        end
    end

    //--------------------------------------------------------------------------
    // Reference model
    //--------------------------------------------------------------------------
    typedef struct {
        int cyc;
        int fc;
        bit ir;
        bit st;
        bit lk;
        bit ov;
        int fc4;
        bit st4;
        bit ov4;
        bit sat4;
    } exp_t;

    exp_t sb_q[$];
    exp_t ent;

    int   cyc      = 0;
    int   m_pos    = -1;   // -1 idle, 0..W-1 gate position, W closing cycle
    int   m_acc    = 0;    // raw edges this window, never saturated
    int   m_consec = 0;
    bit   m_s0 = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0;
    bit   m_det;
    bit   m_latch;
    bit   m_ir;

    logic [15:0] e_fc  = '0;
    logic        e_ir  = 1'b0;
    logic        e_st  = 1'b0;
    logic        e_lk  = 1'b0;
    logic        e_ov  = 1'b0;
    logic [3:0]  e_fc4 = '0;
    logic        e_st4 = 1'b0;
    logic        e_ov4 = 1'b0;
`ifdef CLKMON_HIST_EN
    logic [15:0] e_hmin = 16'hFFFF;
    logic [15:0] e_hmax = '0;
`endif

    always @(posedge clk) begin
        // A rise sampled two clocks ago becomes a counted edge now.
        m_det   = m_s1 && !m_s2;
        m_latch = (m_pos == W);
        if (m_latch) begin
            ent = '{default: 0};
            ent.cyc = cyc;
            if (!reset) begin
                ent.fc   = (m_acc > 65535) ? 65535 : m_acc;
                m_ir     = (ent.fc >= MINC) && (ent.fc <= MAXC);
                m_consec = m_ir ? ((m_consec + 1 > LOCKN) ? LOCKN : m_consec + 1) : 0;
                ent.ir   = m_ir;
                ent.st   = (m_acc == 0);
                ent.lk   = m_ir && (m_consec == LOCKN);
                ent.ov   = (m_acc > 65535);
                ent.fc4  = (m_acc > 15) ? 15 : m_acc;
                ent.st4  = (m_acc == 0);
                ent.ov4  = (m_acc > 15);
                ent.sat4 = (m_acc >= 15);
            end
            sb_q.push_back(ent);
        end
        if (reset) begin
            m_pos = -1; m_acc = 0; m_consec = 0;
            e_fc = '0; e_ir = 0; e_st = 0; e_lk = 0; e_ov = 0;
            e_fc4 = '0; e_st4 = 0; e_ov4 = 0;
            m_s0 = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            if (m_latch) begin
                e_fc  = 16'(ent.fc); e_ir = ent.ir; e_st = ent.st;
                e_lk  = ent.lk;      e_ov = ent.ov;
                e_fc4 = 4'(ent.fc4); e_st4 = ent.st4; e_ov4 = ent.ov4;
                m_acc = (enable && m_det) ? 1 : 0;
                m_pos = enable ? 0 : -1;
            end else if (m_pos >= 0) begin
                if (!enable) begin
                    m_pos = -1; m_acc = 0; m_consec = 0; e_lk = 0;
                end else begin
                    if (m_det) m_acc++;
                    m_pos = (m_pos == W - 1) ? W : m_pos + 1;
                end
            end else begin
                m_acc = 0;
                if (enable) m_pos = 0;
            end
            m_s2 = m_s1; m_s1 = m_s0; m_s0 = meas_in;
        end
`ifdef CLKMON_HIST_EN
        if (reset || hist_clear) begin
            e_hmin = 16'hFFFF;
            e_hmax = '0;
        end else if (m_latch) begin
            if (ent.fc < int'(e_hmin)) e_hmin = 16'(ent.fc);
            if (ent.fc > int'(e_hmax)) e_hmax = 16'(ent.fc);
        end
`endif
        cyc++;
    end

    //--------------------------------------------------------------------------
    // Scoreboard monitor
    //--------------------------------------------------------------------------
    bit   mon_pend = 1'b0;
    int   mon_cyc  = 0;
    exp_t got;

    always @(negedge clk) begin
        if (mon_pend) begin
            mon_pend = 1'b0;
            chk("sb_entry_present", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                got = sb_q.pop_front();
                chk("sb_window_cycle", 64'(mon_cyc), 64'(got.cyc));
                chk("sb_freq_count", 64'(freq_count), 64'(got.fc));
                chk("sb_flags", 64'({in_range, stuck, locked, overflow}),
                    64'({got.ir, got.st, got.lk, got.ov}));
                chk("sb_ovf_count", 64'(freq_count4), 64'(got.fc4));
                chk("sb_ovf_flags", 64'({stuck4, overflow4}), 64'({got.st4, got.ov4}));
                if (got.sat4) chk("sb_ovf_in_range", 64'(in_range4), 64'(0));
            end
        end
        if (count_valid) begin
            mon_pend = 1'b1;
            mon_cyc  = cyc;
        end
    end

    //--------------------------------------------------------------------------
    // Cycle-by-cycle status check
    //--------------------------------------------------------------------------
    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("status", 64'({count_valid, freq_count, in_range, stuck, locked, overflow}),
                64'({(m_pos == W), e_fc, e_ir, e_st, e_lk, e_ov}));
            chk("ovf_status", 64'({count_valid4, freq_count4, stuck4, overflow4}),
                64'({(m_pos == W), e_fc4, e_st4, e_ov4}));
`ifdef CLKMON_HIST_EN
            chk("hist", 64'({hist_min, hist_max}), 64'({e_hmin, e_hmax}));
`endif
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    task automatic wait_cv(input int limit);
        int n;
        n = 0;
        while (!count_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_count_valid", 64'(count_valid), 64'(1));
    endtask

    task automatic measure_latency(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!count_valid && n < 300);
        chk(nm, 64'(n), 64'(W + 1));
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
`ifdef CLKMON_HIST_EN
        hist_clear = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_outputs", 64'({freq_count, count_valid, in_range, stuck, locked, overflow}), 64'(0));
        reset = 1'b0;

        // Steady period-4 wave: 25 edges per window, lock after 4 windows.
        wave_on = 1'b1;
        enable  = 1'b1;
        repeat (6 * (W + 1)) @(negedge clk);
        chk("lock_count", 64'(freq_count), 64'(25));
        chk("lock_flags", 64'({in_range, stuck, locked}), 64'(3'b101));
        chk("cw4_saturate", 64'({freq_count4, overflow4, in_range4}), 64'({4'hF, 1'b1, 1'b0}));

        // Held low: a stuck window drops lock, then the wave re-locks.
        wave_on = 1'b0;
        repeat (210) @(negedge clk);
        chk("stuck_flags", 64'({freq_count, in_range, stuck, locked}), 64'({16'd0, 3'b010}));
        wave_on = 1'b1;
        repeat (5 * (W + 1) + 10) @(negedge clk);
        chk("relock", 64'(locked), 64'(1));

        // Enable dropped at gate cycle 50, then re-enabled.
        wait_cv(300);
        repeat (51) @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_unlock", 64'(locked), 64'(0));
        repeat ($urandom_range(3, 30)) @(negedge clk);
        enable = 1'b1;
        measure_latency("reenable_latency");

        // Reset mid-window.
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", 64'({freq_count, count_valid, in_range, stuck, locked, overflow}), 64'(0));
        reset = 1'b0;
        measure_latency("reset_latency");

        // Randomized mix of waves, gaps, aborts, resets and history clears.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    wave_on = 1'b1; wave_rand = 1'b0;
                    repeat ($urandom_range(W, 5 * W)) @(negedge clk);
                end
                1: begin
                    wave_on = 1'b1; wave_rand = 1'b1;
                    repeat ($urandom_range(W, 3 * W)) @(negedge clk);
                end
                2: begin
                    wave_on = 1'b0;
                    repeat ($urandom_range(50, 250)) @(negedge clk);
                end
                3: begin
                    enable = 1'b0;
                    repeat ($urandom_range(1, 20)) @(negedge clk);
                    enable = 1'b1;
                end
                4: begin
                    reset = 1'b1;
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                    reset = 1'b0;
                end
                default: begin
`ifdef CLKMON_HIST_EN
                    hist_clear = 1'b1;
                    @(negedge clk);
                    hist_clear = 1'b0;
`endif
                    repeat ($urandom_range(10, 150)) @(negedge clk);
                end
            endcase
        end

        enable  = 1'b0;
        wave_on = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
